// File: rtl/cancel_dispatcher_if.sv
// Handshake bundle between the cancel dispatcher and its neighbours:
// command input, decrease-engine port, response output and status.
interface cancel_dispatcher_if #(
  parameter int ORDER_W = 32,
  parameter int QTY_W   = 16,
  parameter int SIZE_W  = 8
);
  logic               msg_valid;
  logic               msg_ready;
  logic [ORDER_W-1:0] msg_id;
  logic [QTY_W-1:0]   msg_qty;
  logic               msg_delete;
  logic               size_inc;
  logic               dec_start;
  logic [ORDER_W-1:0] dec_id;
  logic [QTY_W-1:0]   dec_quantity;
  logic               dec_delete;
  logic [SIZE_W-1:0]  dec_size;
  logic               dec_ready;
  logic [2:0]         dec_update;
  logic [SIZE_W-1:0]  book_size;
  logic               busy;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ORDER_W-1:0] rsp_id;
  logic [2:0]         rsp_code;
  logic [15:0]        cnt_deleted;
  logic [15:0]        cnt_reduced;
  logic [15:0]        cnt_missed;

  modport master (
    input  msg_valid, msg_id, msg_qty, msg_delete,
    input  size_inc, dec_ready, dec_update, rsp_ready,
    output msg_ready, dec_start, dec_id, dec_quantity,
    output dec_delete, dec_size, book_size, busy,
    output rsp_valid, rsp_id, rsp_code,
    output cnt_deleted, cnt_reduced, cnt_missed
  );

  modport slave (
    output msg_valid, msg_id, msg_qty, msg_delete,
    output size_inc, dec_ready, dec_update, rsp_ready,
    input  msg_ready, dec_start, dec_id, dec_quantity,
    input  dec_delete, dec_size, book_size, busy,
    input  rsp_valid, rsp_id, rsp_code,
    input  cnt_deleted, cnt_reduced, cnt_missed
  );
endinterface

// File: rtl/cancel_dispatcher.sv
// Cancel/reduce command dispatcher: FIFO, one-at-a-time engine issue,
// authoritative book size, per-command response and event counters.
module cancel_dispatcher #(
  parameter int ORDER_W    = 32,
  parameter int QTY_W      = 16,
  parameter int SIZE_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk_in,
  input logic rst_n,
  cancel_dispatcher_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] C_DEL = 3'b010;
  localparam logic [2:0] C_UPD = 3'b110;
  localparam logic [2:0] C_NF  = 3'b111;
  localparam logic [2:0] C_REJ = 3'b100;

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  typedef struct packed {
    logic [ORDER_W-1:0] id;
    logic [QTY_W-1:0]   qty;
    logic               del;
  } cmd_t;

  cmd_t              mem_q [FIFO_DEPTH];
  cmd_t              mem_d [FIFO_DEPTH];
  logic [AW:0]       wr_q, wr_d;
  logic [AW:0]       rd_q, rd_d;
  state_t            st_q, st_d;
  cmd_t              cur_q, cur_d;
  logic [2:0]        code_q, code_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [SIZE_W-1:0] dsz_q, dsz_d;
  logic [15:0]       cdel_q, cdel_d;
  logic [15:0]       cred_q, cred_d;
  logic [15:0]       cmis_q, cmis_d;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic dec_ev;
  cmd_t head;

  assign fifo_empty = (wr_q == rd_q);
  assign fifo_full  = (wr_q[AW] != rd_q[AW]) &&
                      (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push = bus.msg_valid && !fifo_full;
  assign pop  = (st_q == IDLE) && !fifo_empty;
  assign head = mem_q[rd_q[AW-1:0]];

  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    st_d   = st_q;
    cur_d  = cur_q;
    code_d = code_q;
    dsz_d  = dsz_q;
    cdel_d = cdel_q;
    cred_d = cred_q;
    cmis_d = cmis_q;
    dec_ev = 1'b0;
    if (push) begin
      mem_d[wr_q[AW-1:0]] = '{bus.msg_id, bus.msg_qty,
                              bus.msg_delete};
      wr_d = wr_q + (AW+1)'(1);
    end
    unique case (st_q)
      IDLE: begin
        if (pop) begin
          rd_d  = rd_q + (AW+1)'(1);
          cur_d = head;
          // Zero-quantity reduce is malformed; empty book cannot match
          if (head.qty == '0 && !head.del) begin
            st_d   = RESP;
            code_d = C_REJ;
          end else if (size_q == '0) begin
            st_d   = RESP;
            code_d = C_NF;
          end else begin
            st_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        dsz_d = size_q;
        st_d  = WAIT;
      end
      WAIT: begin
        if (bus.dec_ready) begin
          code_d = bus.dec_update;
          dec_ev = (bus.dec_update == C_DEL);
          st_d   = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          st_d = IDLE;
          unique case (1'b1)
            code_q == C_DEL: cdel_d = cdel_q + 16'd1;
            code_q == C_UPD: cred_d = cred_q + 16'd1;
            code_q == C_NF:  cmis_d = cmis_q + 16'd1;
            default: ;
          endcase
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    size_d = size_q;
    if (bus.size_inc && !dec_ev && size_q != '1)
      size_d = size_q + SIZE_W'(1);
    else if (dec_ev && !bus.size_inc && size_q != '0)
      size_d = size_q - SIZE_W'(1);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      st_q   <= IDLE;
      cur_q  <= '0;
      code_q <= '0;
      size_q <= '0;
      dsz_q  <= '0;
      cdel_q <= '0;
      cred_q <= '0;
      cmis_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      st_q   <= st_d;
      cur_q  <= cur_d;
      code_q <= code_d;
      size_q <= size_d;
      dsz_q  <= dsz_d;
      cdel_q <= cdel_d;
      cred_q <= cred_d;
      cmis_q <= cmis_d;
    end
  end

  assign bus.msg_ready    = !fifo_full;
  assign bus.dec_start    = (st_q == ISSUE);
  assign bus.dec_id       = cur_q.id;
  assign bus.dec_quantity = cur_q.qty;
  assign bus.dec_delete   = cur_q.del;
  assign bus.dec_size     = (st_q == ISSUE) ? size_q : dsz_q;
  assign bus.book_size    = size_q;
  assign bus.busy         = (st_q != IDLE) || !fifo_empty;
  assign bus.rsp_valid    = (st_q == RESP);
  assign bus.rsp_id       = cur_q.id;
  assign bus.rsp_code     = code_q;
  assign bus.cnt_deleted  = cdel_q;
  assign bus.cnt_reduced  = cred_q;
  assign bus.cnt_missed   = cmis_q;
endmodule

// File: tb/tb_cancel_dispatcher.sv
// Bench for cancel_dispatcher: directed plan steps plus a random
// phase, checked against a command-level scoreboard and engine model.
module tb_cancel_dispatcher;
  localparam int OW = 32;
  localparam int QW = 16;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cancel_dispatcher_if #(.ORDER_W(OW), .QTY_W(QW), .SIZE_W(SW)) bus();

  cancel_dispatcher #(
    .ORDER_W(OW), .QTY_W(QW), .SIZE_W(SW), .FIFO_DEPTH(4)
  ) dut (
    .clk_in(clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  typedef struct {
    logic [31:0] id;
    logic [15:0] qty;
    logic        del;
    logic        started;
    logic [2:0]  code;
  } cmd_t;

  cmd_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          msize = 0;
  logic [15:0] m_del = 0, m_red = 0, m_mis = 0;
  int          starts = 0;
  int          eng_cnt = 0;
  int          eng_lat = 1;
  logic [2:0]  eng_code = 3'b010;
  bit          eng_rand = 0;
  bit          eng_real = 0;
  bit          inc_mirror = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] rand_code();
    case ($urandom_range(0, 2))
      0: return 3'b010;
      1: return 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  task automatic engine_step();
    cmd_t c;
    if (bus.dec_ready) begin
      bus.dec_ready = 1'b0;
      eng_real = 0;
    end
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0 && sb.size() != 0) begin
        bus.dec_ready  = 1'b1;
        bus.dec_update = sb[0].code;
        eng_real = 1;
        chk("hold_id", bus.dec_id, sb[0].id);
        chk("hold_qty", bus.dec_quantity, sb[0].qty);
      end
    end
    if (bus.dec_start) begin
      starts++;
      chk("dec_size", bus.dec_size, msize);
      chk("start_nonempty_book", msize != 0, 1);
      if (sb.size() == 0) begin
        chk("start_without_cmd", 1, 0);
      end else begin
        c = sb[0];
        chk("dec_id", bus.dec_id, c.id);
        chk("dec_qty", bus.dec_quantity, c.qty);
        chk("dec_delete", bus.dec_delete, c.del);
        chk("start_on_reject", (c.qty == 0 && !c.del), 0);
        c.started = 1;
        c.code = eng_rand ? rand_code() : eng_code;
        sb[0] = c;
      end
      eng_cnt = eng_rand ? $urandom_range(1, 4) : eng_lat;
    end
    if (inc_mirror) bus.size_inc = bus.dec_ready;
  endtask

  task automatic cyc();
    bit inc, dec, push, hs;
    logic [31:0] rid;
    logic [2:0]  rc, exp;
    cmd_t pc, hc;
    inc  = bus.size_inc;
    dec  = bus.dec_ready && eng_real && bus.dec_update == 3'b010;
    push = bus.msg_valid && bus.msg_ready;
    hs   = bus.rsp_valid && bus.rsp_ready;
    rid  = bus.rsp_id;
    rc   = bus.rsp_code;
    pc.id = bus.msg_id;
    pc.qty = bus.msg_qty;
    pc.del = bus.msg_delete;
    pc.started = 0;
    pc.code = 3'b000;
    @(negedge clk);
    if (inc && !dec && msize < 255) msize++;
    else if (dec && !inc && msize > 0) msize--;
    if (hs) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        hc = sb.pop_front();
        if (hc.started) exp = hc.code;
        else if (hc.qty == 0 && !hc.del) exp = 3'b100;
        else exp = 3'b111;
        chk("rsp_id", rid, hc.id);
        chk("rsp_code", rc, exp);
        if (exp == 3'b010) m_del++;
        if (exp == 3'b110) m_red++;
        if (exp == 3'b111) m_mis++;
        chk("cnt_deleted", bus.cnt_deleted, m_del);
        chk("cnt_reduced", bus.cnt_reduced, m_red);
        chk("cnt_missed", bus.cnt_missed, m_mis);
      end
    end
    if (push) sb.push_back(pc);
    chk("book_size", bus.book_size, msize);
    engine_step();
  endtask

  task automatic send(logic [31:0] id, logic [15:0] q, logic d);
    bit acc;
    int n = 0;
    bus.msg_valid  = 1'b1;
    bus.msg_id     = id;
    bus.msg_qty    = q;
    bus.msg_delete = d;
    do begin
      acc = bus.msg_ready;
      cyc();
      n++;
    end while (!acc && n < 50);
    bus.msg_valid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while ((sb.size() != 0 || bus.busy) && n < budget) begin
      cyc();
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_ctl"}, {bus.dec_start, bus.dec_delete, bus.busy,
        bus.rsp_valid, bus.dec_size, bus.book_size, bus.rsp_code}, 0);
    chk({tag, "_ids"}, {bus.dec_id, bus.rsp_id}, 0);
    chk({tag, "_cnt"}, {bus.dec_quantity, bus.cnt_deleted,
        bus.cnt_reduced, bus.cnt_missed}, 0);
  endtask

  initial begin
    int s0;
    logic [15:0] d0, r0, m0;
    bus.msg_valid  = 1'b0;
    bus.msg_id     = '0;
    bus.msg_qty    = '0;
    bus.msg_delete = 1'b0;
    bus.size_inc   = 1'b0;
    bus.dec_ready  = 1'b0;
    bus.dec_update = 3'b000;
    bus.rsp_ready  = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    cyc();
    chk("ready_after_reset", bus.msg_ready, 1);

    // three adds then a full cancel resolved as DELETE
    bus.size_inc = 1'b1;
    repeat (3) cyc();
    bus.size_inc = 1'b0;
    eng_code = 3'b010;
    eng_lat  = 2;
    send(32'h10, 16'd0, 1'b1);
    wait_idle(50);
    chk("t1_size", bus.book_size, 2);
    chk("t1_cnt_del", bus.cnt_deleted, 1);
    chk("t1_starts", starts, 1);

    // partial reduce resolved as UPDATE
    eng_code = 3'b110;
    send(32'h7, 16'd5, 1'b0);
    wait_idle(50);
    chk("t2_size", bus.book_size, 2);
    chk("t2_cnt_red", bus.cnt_reduced, 1);

    // empty the book, then a cancel short-circuits as NOT_FOUND
    eng_code = 3'b010;
    send(32'h20, 16'd1, 1'b1);
    wait_idle(50);
    send(32'h21, 16'd1, 1'b1);
    wait_idle(50);
    chk("t3_empty", bus.book_size, 0);
    s0 = starts;
    send(32'h9, 16'd3, 1'b1);
    cyc();
    chk("t3_rsp_valid", bus.rsp_valid, 1);
    chk("t3_rsp_code", bus.rsp_code, 3'b111);
    wait_idle(50);
    chk("t3_no_start", starts, s0);
    chk("t3_cnt_mis", bus.cnt_missed, 1);

    // zero-quantity reduce is rejected even with a non-empty book
    bus.size_inc = 1'b1;
    cyc();
    bus.size_inc = 1'b0;
    d0 = bus.cnt_deleted;
    r0 = bus.cnt_reduced;
    m0 = bus.cnt_missed;
    send(32'h30, 16'd0, 1'b0);
    cyc();
    chk("t4_rsp_valid", bus.rsp_valid, 1);
    chk("t4_rsp_code", bus.rsp_code, 3'b100);
    wait_idle(50);
    chk("t4_no_start", starts, s0);
    chk("t4_counters", {bus.cnt_deleted, bus.cnt_reduced,
        bus.cnt_missed}, {d0, r0, m0});

    // back-pressure: five pushes fill the FIFO behind a held response
    bus.rsp_ready = 1'b0;
    eng_code = 3'b110;
    eng_lat  = 1;
    bus.msg_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.msg_id     = 32'h40 + i;
      bus.msg_qty    = 16'd1;
      bus.msg_delete = 1'b0;
      chk($sformatf("t5_ready_%0d", i), bus.msg_ready, 1);
      cyc();
    end
    chk("t5_full", bus.msg_ready, 0);
    bus.msg_id = 32'h4f;
    repeat (3) cyc();
    bus.msg_valid = 1'b0;
    chk("t5_held_valid", bus.rsp_valid, 1);
    chk("t5_held_id", bus.rsp_id, 32'h40);
    chk("t5_still_full", bus.msg_ready, 0);
    chk("t5_busy", bus.busy, 1);
    chk("t5_sb", sb.size(), 5);
    bus.rsp_ready = 1'b1;
    wait_idle(200);
    chk("t5_cnt_red", bus.cnt_reduced, 6);

    // add pulse coincides with DELETE completion
    inc_mirror = 1;
    eng_code = 3'b010;
    eng_lat  = 2;
    send(32'h50, 16'd2, 1'b1);
    wait_idle(50);
    inc_mirror = 0;
    bus.size_inc = 1'b0;
    chk("t6_size", bus.book_size, 1);

    // dec_ready outside WAIT is ignored
    bus.dec_ready  = 1'b1;
    bus.dec_update = 3'b010;
    eng_real = 0;
    repeat (2) cyc();
    chk("t7_size", bus.book_size, 1);
    chk("t7_no_rsp", bus.rsp_valid, 0);

    // random traffic
    eng_rand = 1;
    for (int k = 0; k < 500; k++) begin
      bus.msg_valid  = ($urandom_range(0, 2) == 0);
      bus.msg_id     = $urandom;
      bus.msg_qty    = 16'($urandom_range(0, 3));
      bus.msg_delete = $urandom_range(0, 1) == 1;
      bus.size_inc   = ($urandom_range(0, 4) == 0);
      bus.rsp_ready  = ($urandom_range(0, 3) != 0);
      cyc();
    end
    bus.msg_valid = 1'b0;
    bus.size_inc  = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_idle(400);
    eng_rand = 0;

    // saturation at all-ones
    bus.size_inc = 1'b1;
    repeat (260) cyc();
    bus.size_inc = 1'b0;
    cyc();
    chk("t8_sat", bus.book_size, 255);

    // reset during WAIT abandons the command
    eng_code = 3'b010;
    eng_lat  = 20;
    s0 = starts;
    send(32'h60, 16'd1, 1'b1);
    for (int n = 0; n < 10 && starts == s0; n++) cyc();
    chk("t9_started", starts, s0 + 1);
    repeat (2) cyc();
    #2 rst_n = 1'b0;
    #1 chk_zero("mid_reset");
    msize = 0;
    sb.delete();
    m_del = 0;
    m_red = 0;
    m_mis = 0;
    eng_cnt = 0;
    eng_real = 0;
    bus.dec_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 25; n++) begin
      cyc();
      chk("t9_no_rsp", bus.rsp_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
